// File: rtl/pll_lock_rst_gen.sv
// -----------------------------------------------------------------------------
// pll_lock_rst_gen
//
// Reset sequencer placed directly downstream of sys_pll. It pulses the PLL
// reset, waits for the PLL to lock, debounces the lock indication, and then
// releases the system reset for logic in the clkout0 domain. Once running it
// watches for lock loss and restarts the whole sequence automatically. A lock
// that never arrives is retried after LOCK_TIMEOUT cycles.
//
// Everything runs on clkin1, the free-running PLL reference clock, because
// clkout0 cannot be trusted while the PLL is being reset or is unlocked.
//
// Ports:
//   clkin1      in   free-running PLL reference clock (sole clock)
//   rst         in   synchronous, active-high reset
//   lock        in   PLL lock, asynchronous to clkin1
//   pll_rst     out  reset to sys_pll, active high
//   sys_rst     out  system reset, active high (consumers resync to clkout0)
//   sys_ready   out  high only while in RUN
//   lock_lost   out  sticky flag, set on the first lock loss seen in RUN
//   timeout_cnt out  number of lock-timeout retries, saturates at 255
//   loss_cnt    out  number of lock losses seen in RUN, saturates at 255
// -----------------------------------------------------------------------------
module pll_lock_rst_gen #(
  parameter int PLL_RST_CYCLES     = 20,
  parameter int LOCK_TIMEOUT       = 20000,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int SYS_RST_HOLD       = 64
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       sys_ready,
  output logic       lock_lost,
  output logic [7:0] timeout_cnt,
  output logic [7:0] loss_cnt
);

  // ---------------------------------------------------------------------------
  // Counter sizing: wide enough for the largest per-state cycle budget.
  // ---------------------------------------------------------------------------
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > SYS_RST_HOLD) ? LOCK_STABLE_CYCLES : SYS_RST_HOLD;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  // Terminal count values, one per timed state.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SYS_RST_HOLD - 1);

  // The lock_s sample that moves WAIT_LOCK into STABLE is already the first of
  // the consecutive high samples, so STABLE itself only needs to see
  // LOCK_STABLE_CYCLES-1 more. With LOCK_STABLE_CYCLES==1 STABLE is skipped.
  localparam logic [CNT_W-1:0] STABLE_LAST  =
    CNT_W'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam bit STABLE_SKIP = (LOCK_STABLE_CYCLES == 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Saturating 8-bit increment used by both status counters.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Saturating increment for the state cycle counter; RUN has no time limit,
  // so the counter must not wrap while it idles there.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic             lock_meta_r;
  logic             lock_sync_r;   // lock_s: the only lock view used below
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pll_rst_r;
  logic             sys_rst_r;
  logic             sys_ready_r;
  logic             lock_lost_r;
  logic [7:0]       timeout_cnt_r;
  logic [7:0]       loss_cnt_r;

  state_t           next_state_s;
  logic             timeout_inc_s;
  logic             loss_inc_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Two-flop synchronizer bringing the asynchronous lock pin into clkin1.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= lock;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state decision and counter-event strobes.
  always_comb begin
    next_state_s  = ST_PLL_RST;
    timeout_inc_s = 1'b0;
    loss_inc_s    = 1'b0;
    case (state_r)
      ST_PLL_RST: begin
        if (cnt_r == PLL_RST_LAST) begin
          next_state_s = ST_WAIT_LOCK;
        end else begin
          next_state_s = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_sync_r) begin
          if (STABLE_SKIP) begin
            next_state_s = ST_HOLD;
          end else begin
            next_state_s = ST_STABLE;
          end
        end else if (cnt_r == TIMEOUT_LAST) begin
          next_state_s  = ST_PLL_RST;
          timeout_inc_s = 1'b1;
        end else begin
          next_state_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        // A drop here is treated as a glitch: back to waiting, fresh window.
        if (!lock_sync_r) begin
          next_state_s = ST_WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_STABLE;
        end
      end
      ST_HOLD: begin
        if (!lock_sync_r) begin
          next_state_s = ST_WAIT_LOCK;
        end else if (cnt_r == HOLD_LAST) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (!lock_sync_r) begin
          next_state_s = ST_PLL_RST;
          loss_inc_s   = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: begin
        // Unused encodings recover through a full PLL reset.
        next_state_s = ST_PLL_RST;
      end
    endcase
  end

  // Cycle counter restarts from zero on every state change.
  always_comb begin
    cnt_next_s = '0;
    if (next_state_s != state_r) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = sat_inc_cnt(cnt_r);
    end
  end

  // Sequencer registers; outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      state_r       <= ST_PLL_RST;
      cnt_r         <= '0;
      pll_rst_r     <= 1'b1;
      sys_rst_r     <= 1'b1;
      sys_ready_r   <= 1'b0;
      lock_lost_r   <= 1'b0;
      timeout_cnt_r <= 8'd0;
      loss_cnt_r    <= 8'd0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= cnt_next_s;
      pll_rst_r   <= (next_state_s == ST_PLL_RST);
      sys_rst_r   <= (next_state_s != ST_RUN);
      sys_ready_r <= (next_state_s == ST_RUN);
      if (loss_inc_s) begin
        lock_lost_r <= 1'b1;
        loss_cnt_r  <= sat_inc8(loss_cnt_r);
      end
      if (timeout_inc_s) begin
        timeout_cnt_r <= sat_inc8(timeout_cnt_r);
      end
    end
  end

  assign pll_rst     = pll_rst_r;
  assign sys_rst     = sys_rst_r;
  assign sys_ready   = sys_ready_r;
  assign lock_lost   = lock_lost_r;
  assign timeout_cnt = timeout_cnt_r;
  assign loss_cnt    = loss_cnt_r;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pll_lock_rst_gen
//
// Directed bench for pll_lock_rst_gen with small parameters. The stimulus
// process schedules expected output vectors at absolute edge indices; the
// monitor compares them as the DUT reaches those edges.
// -----------------------------------------------------------------------------
module tb_pll_lock_rst_gen;

  localparam int P_RST  = 4;
  localparam int P_TO   = 32;
  localparam int P_STAB = 8;
  localparam int P_HOLD = 4;
  localparam int PERIOD = P_RST + P_TO;   // one timeout retry loop

  logic       clkin1 = 1'b0;
  logic       rst    = 1'b1;
  logic       lock   = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       sys_ready;
  logic       lock_lost;
  logic [7:0] timeout_cnt;
  logic [7:0] loss_cnt;

  pll_lock_rst_gen #(
    .PLL_RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT      (P_TO),
    .LOCK_STABLE_CYCLES(P_STAB),
    .SYS_RST_HOLD      (P_HOLD)
  ) dut (
    .clkin1     (clkin1),
    .rst        (rst),
    .lock       (lock),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .sys_ready  (sys_ready),
    .lock_lost  (lock_lost),
    .timeout_cnt(timeout_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clkin1 = ~clkin1;

  // edge_n = number of rising edges so far; stable at every falling edge.
  int edge_n = 0;
  always @(posedge clkin1) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  // Scoreboard: parallel queues of (edge index, name, expected vector).
  int          exp_cyc[$];
  string       exp_nm[$];
  logic [19:0] exp_v[$];

  logic [19:0] act;
  assign act = {pll_rst, sys_rst, sys_ready, lock_lost, timeout_cnt, loss_cnt};

  function automatic logic [19:0] ov(input logic p, input logic s, input logic r,
                                     input logic l, input int t, input int c);
    logic [7:0] t8;
    logic [7:0] c8;
    t8 = t[7:0];
    c8 = c[7:0];
    return {p, s, r, l, t8, c8};
  endfunction

  task automatic expect_at(input int cyc, input string nm, input logic [19:0] v);
    exp_cyc.push_back(cyc);
    exp_nm.push_back(nm);
    exp_v.push_back(v);
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clkin1);
  endtask

  // Returns the edge index at which rst was sampled high.
  task automatic do_reset(output int r);
    @(negedge clkin1);
    rst = 1'b1;
    @(negedge clkin1);
    rst = 1'b0;
    r = edge_n;
  endtask

  // Monitor: compares every scheduled expectation due at this edge.
  always @(negedge clkin1) begin
    for (int i = exp_cyc.size() - 1; i >= 0; i--) begin
      if (exp_cyc[i] == edge_n) begin
        total = total + 1;
        if (act !== exp_v[i]) begin
          bad = bad + 1;
          $display("FAIL %s edge=%0d got={pll_rst,sys_rst,ready,lost,tcnt,lcnt}=%h want=%h",
                   exp_nm[i], edge_n, act, exp_v[i]);
        end
        exp_cyc.delete(i);
        exp_nm.delete(i);
        exp_v.delete(i);
      end
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog edge=%0d got=timeout want=finish", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int k;
    int d;
    int d2;
    int k3;

    // ---------------- Test 1: no lock, timeout retries and saturation -------
    lock = 1'b0;
    do_reset(r);
    expect_at(r + 1,  "t1_reset",      ov(1, 1, 0, 0, 0, 0));
    expect_at(r + 3,  "t1_prst_last",  ov(1, 1, 0, 0, 0, 0));
    expect_at(r + 4,  "t1_wait_first", ov(0, 1, 0, 0, 0, 0));
    expect_at(r + 35, "t1_wait_last",  ov(0, 1, 0, 0, 0, 0));
    expect_at(r + 36, "t1_retry1",     ov(1, 1, 0, 0, 1, 0));
    expect_at(r + 39, "t1_retry1_end", ov(1, 1, 0, 0, 1, 0));
    expect_at(r + 40, "t1_wait2",      ov(0, 1, 0, 0, 1, 0));
    expect_at(r + PERIOD * 255 - 1,  "t1_pre_sat",  ov(0, 1, 0, 0, 254, 0));
    expect_at(r + PERIOD * 255,      "t1_sat",      ov(1, 1, 0, 0, 255, 0));
    expect_at(r + PERIOD * 300 + 1,  "t1_sat_hold", ov(1, 1, 0, 0, 255, 0));
    expect_at(r + PERIOD * 300 + 10, "t1_sat_wait", ov(0, 1, 0, 0, 255, 0));
    wait_to(r + PERIOD * 300 + 12);
    total = total + 1;
    if (timeout_cnt !== 8'd255) begin
      bad = bad + 1;
      $display("FAIL t1_sat_final edge=%0d got=%0d want=255", edge_n, timeout_cnt);
    end

    // ---------------- Test 2: clean lock, RUN after 1+8+4 -----------------
    lock = 1'b0;
    do_reset(r);
    k = r + 10;
    expect_at(r + 1,  "t2_reset",     ov(1, 1, 0, 0, 0, 0));
    expect_at(k + 1,  "t2_waiting",   ov(0, 1, 0, 0, 0, 0));
    expect_at(k + 12, "t2_pre_run",   ov(0, 1, 0, 0, 0, 0));
    expect_at(k + 13, "t2_run",       ov(0, 0, 1, 0, 0, 0));
    expect_at(k + 20, "t2_run_stays", ov(0, 0, 1, 0, 0, 0));
    wait_to(k - 1);
    lock = 1'b1;
    wait_to(k + 22);
    total = total + 1;
    if (sys_ready !== 1'b1 || sys_rst !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL t2_run_final edge=%0d got=%b%b want=10", edge_n, sys_ready, sys_rst);
    end

    // ---------------- Test 3: one-cycle glitch in STABLE -------------------
    lock = 1'b0;
    do_reset(r);
    k = r + 10;
    expect_at(k + 8,  "t3_glitch",      ov(0, 1, 0, 0, 0, 0));
    expect_at(k + 13, "t3_no_early",    ov(0, 1, 0, 0, 0, 0));
    expect_at(k + 19, "t3_pre_run",     ov(0, 1, 0, 0, 0, 0));
    expect_at(k + 20, "t3_run_delayed", ov(0, 0, 1, 0, 0, 0));
    wait_to(k - 1);
    lock = 1'b1;
    wait_to(k + 5);
    lock = 1'b0;          // pin low at edge k+6 only
    wait_to(k + 6);
    lock = 1'b1;          // re-rise at edge k+7
    wait_to(k + 22);

    // ---------------- Test 4: lock loss in RUN ------------------------------
    d = k + 25;           // pin low sampled at edge d
    expect_at(d + 1,  "t4_run_still", ov(0, 0, 1, 0, 0, 0));
    expect_at(d + 2,  "t4_loss",      ov(1, 1, 0, 1, 0, 1));
    expect_at(d + 5,  "t4_prst_end",  ov(1, 1, 0, 1, 0, 1));
    expect_at(d + 6,  "t4_wait",      ov(0, 1, 0, 1, 0, 1));
    expect_at(d + 22, "t4_pre_rerun", ov(0, 1, 0, 1, 0, 1));
    expect_at(d + 23, "t4_rerun",     ov(0, 0, 1, 1, 0, 1));
    wait_to(d - 1);
    lock = 1'b0;
    wait_to(d + 9);
    lock = 1'b1;          // recovers at edge d+10
    wait_to(d + 25);
    total = total + 1;
    if (sys_ready !== 1'b1 || lock_lost !== 1'b1 || loss_cnt !== 8'd1) begin
      bad = bad + 1;
      $display("FAIL t4_rerun_final edge=%0d got=%b%b%0d want=111",
               edge_n, sys_ready, lock_lost, loss_cnt);
    end

    // ---------------- Test 5: rst pulse while in HOLD -----------------------
    d2 = d + 30;
    k3 = d2 + 10;
    expect_at(d2 + 2,  "t5_loss2",   ov(1, 1, 0, 1, 0, 2));
    expect_at(k3 + 9,  "t5_hold",    ov(0, 1, 0, 1, 0, 2));
    expect_at(k3 + 10, "t5_rst",     ov(1, 1, 0, 0, 0, 0));
    expect_at(k3 + 13, "t5_prst",    ov(1, 1, 0, 0, 0, 0));
    expect_at(k3 + 14, "t5_wait",    ov(0, 1, 0, 0, 0, 0));
    expect_at(k3 + 25, "t5_pre_run", ov(0, 1, 0, 0, 0, 0));
    expect_at(k3 + 26, "t5_rerun",   ov(0, 0, 1, 0, 0, 0));
    wait_to(d2 - 1);
    lock = 1'b0;
    wait_to(k3 - 1);
    lock = 1'b1;
    wait_to(k3 + 9);
    rst = 1'b1;
    wait_to(k3 + 10);
    rst = 1'b0;
    wait_to(k3 + 30);

    // ---------------- Test 6: lock toggling every 3 cycles ------------------
    lock = 1'b0;
    do_reset(r);
    expect_at(r + 1, "t6_reset", ov(1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      expect_at(r + 10 + 10 * i, "t6_no_run", ov(0, 1, 0, 0, 0, 0));
    end
    for (int j = 0; j < 40; j++) begin
      wait_to(r + 8 + 3 * j);
      lock = ~lock;
    end
    wait_to(r + 130);
    total = total + 1;
    if (sys_rst !== 1'b1 || sys_ready !== 1'b0 || timeout_cnt !== 8'd0 || loss_cnt !== 8'd0) begin
      bad = bad + 1;
      $display("FAIL t6_final edge=%0d got=%b%b%0d%0d want=1000",
               edge_n, sys_rst, sys_ready, timeout_cnt, loss_cnt);
    end
    lock = 1'b0;

    // Any expectation never reached counts as a failure.
    wait_to(edge_n + 3);
    while (exp_cyc.size() > 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL unchecked_%s edge=%0d got=none want=%h",
               exp_nm[0], exp_cyc[0], exp_v[0]);
      void'(exp_cyc.pop_front());
      void'(exp_nm.pop_front());
      void'(exp_v.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
